// File: rtl/risc8_gpio.sv
// RISC8 general-purpose I/O block: PIN/DDR/PORT registers, synchronised pad inputs,
// per-bit rise/fall edge flags with write-1-to-clear and a registered level interrupt.
module risc8_gpio #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             we,
    input  logic             re,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] port_out,
    output logic [WIDTH-1:0] ddr_out,
    input  logic [WIDTH-1:0] pin_in,
    output logic             irq
);

    localparam logic [2:0] ADDR_PIN     = 3'd0;
    localparam logic [2:0] ADDR_DDR     = 3'd1;
    localparam logic [2:0] ADDR_PORT    = 3'd2;
    localparam logic [2:0] ADDR_RISE_EN = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN = 3'd4;
    localparam logic [2:0] ADDR_FLAG    = 3'd5;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_ddr;
    logic [WIDTH-1:0] r_port;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_flag;
    logic [WIDTH-1:0] r_rdata;
    logic             r_irq;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_flag_next;
    logic [WIDTH-1:0] w_port_next;
    logic [WIDTH-1:0] w_rd_mux;

    // Oldest stage of the shift chain is the synchronised pin value.
    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_prev;
    assign w_fall = ~w_sync & r_prev;
    assign w_set  = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr  = (we && (addr == ADDR_FLAG)) ? wdata : '0;

    // Set is OR'ed in after the clear so a coincident edge keeps its flag.
    assign w_flag_next = (r_flag & ~w_clr) | w_set;

    always_comb begin
        w_port_next = r_port;
        if (we) begin
            case (addr)
                ADDR_PIN:  w_port_next = r_port ^ wdata;
                ADDR_PORT: w_port_next = wdata;
                default:   w_port_next = r_port;
            endcase
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (addr)
            ADDR_PIN:     w_rd_mux = w_sync;
            ADDR_DDR:     w_rd_mux = r_ddr;
            ADDR_PORT:    w_rd_mux = r_port;
            ADDR_RISE_EN: w_rd_mux = r_rise_en;
            ADDR_FALL_EN: w_rd_mux = r_fall_en;
            ADDR_FLAG:    w_rd_mux = r_flag;
            default:      w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pin_in};
            r_prev <= w_sync;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ddr     <= '0;
            r_port    <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_flag    <= '0;
            r_rdata   <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_port <= w_port_next;
            if (we && (addr == ADDR_DDR))     r_ddr     <= wdata;
            if (we && (addr == ADDR_RISE_EN)) r_rise_en <= wdata;
            if (we && (addr == ADDR_FALL_EN)) r_fall_en <= wdata;
            r_flag <= w_flag_next;
            // irq trails the flag register by one cycle and masks by current enables.
            r_irq  <= |(r_flag & (r_rise_en | r_fall_en));
            if (re) r_rdata <= w_rd_mux;
        end
    end

    assign rdata    = r_rdata;
    assign port_out = r_port;
    assign ddr_out  = r_ddr;
    assign irq      = r_irq;

endmodule

// File: tb/tb_risc8_gpio.sv
// Bench for risc8_gpio: directed scenarios plus randomized traffic against a
// pin-history reference model; a second WIDTH=4/SYNC_STAGES=3 instance covers parameters.
module tb_risc8_gpio;

    localparam int SY  = 2;
    localparam int SY4 = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] addr = 3'd0;
    logic [7:0] wdata = 8'h00;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic [7:0] pin_in = 8'hFF;
    logic [7:0] rdata, port_out, ddr_out;
    logic       irq;

    logic [2:0] addr4 = 3'd0;
    logic [3:0] wdata4 = 4'h0;
    logic       we4 = 1'b0;
    logic       re4 = 1'b0;
    logic [3:0] pin4 = 4'hF;
    logic [3:0] rdata4, port4, ddr4;
    logic       irq4;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] m_port, m_ddr, m_ren, m_fen, m_flag, m_rdata;
    logic       m_irq;
    logic [7:0] hist[$];

    risc8_gpio #(.WIDTH(8), .SYNC_STAGES(SY)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .port_out(port_out), .ddr_out(ddr_out), .pin_in(pin_in), .irq(irq)
    );

    risc8_gpio #(.WIDTH(4), .SYNC_STAGES(SY4)) dut4 (
        .clk(clk), .reset(reset), .addr(addr4), .wdata(wdata4), .we(we4), .re(re4),
        .rdata(rdata4), .port_out(port4), .ddr_out(ddr4), .pin_in(pin4), .irq(irq4)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_port = 0; m_ddr = 0; m_ren = 0; m_fen = 0; m_flag = 0; m_rdata = 0; m_irq = 0;
        hist.delete();
        repeat (SY + 1) hist.push_back(8'h00);
    endtask

    // One clock: the model derives sync/prev from the history of sampled pad values.
    task automatic tick();
        logic [7:0] s, p, setv, clrv, nflag, rd;
        logic       nirq;
        s = hist[hist.size() - SY];
        p = hist[hist.size() - SY - 1];
        setv  = ((s & ~p) & m_ren) | ((~s & p) & m_fen);
        clrv  = (we && addr == 3'd5) ? wdata : 8'h00;
        nflag = (m_flag & ~clrv) | setv;
        nirq  = |(m_flag & (m_ren | m_fen));
        case (addr)
            3'd0:    rd = s;
            3'd1:    rd = m_ddr;
            3'd2:    rd = m_port;
            3'd3:    rd = m_ren;
            3'd4:    rd = m_fen;
            3'd5:    rd = m_flag;
            default: rd = 8'h00;
        endcase
        @(posedge clk);
        hist.push_back(pin_in);
        if (hist.size() > 8) void'(hist.pop_front());
        if (we) begin
            case (addr)
                3'd0: m_port = m_port ^ wdata;
                3'd1: m_ddr  = wdata;
                3'd2: m_port = wdata;
                3'd3: m_ren  = wdata;
                3'd4: m_fen  = wdata;
                default: ;
            endcase
        end
        if (re) m_rdata = rd;
        m_flag = nflag;
        m_irq  = nirq;
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        addr = a; wdata = d; we = 1'b1; re = 1'b0;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        addr = a; re = 1'b1; we = 1'b0;
        tick();
        re = 1'b0;
    endtask

    task automatic wr4(input logic [2:0] a, input logic [3:0] d);
        addr4 = a; wdata4 = d; we4 = 1'b1;
        tick();
        we4 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (port_out !== 8'h00) begin n_err++; $display("FAIL reset_port_out got %h want 00", port_out); end
        n_cmp++; if (ddr_out !== 8'h00) begin n_err++; $display("FAIL reset_ddr_out got %h want 00", ddr_out); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
        n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata got %h want 00", rdata); end
        reset = 1'b0;
        model_reset();
        // Pads held high through reset must appear as rising edges once released.
        wr(3'd3, 8'hFF);
        repeat (3) tick();
        rd(3'd5);
        n_cmp++; if (rdata !== 8'hFF) begin n_err++; $display("FAIL reset_release_rise got %h want FF", rdata); end
    endtask

    task automatic test_toggle();
        wr(3'd2, 8'hA5);
        wr(3'd0, 8'h0F);
        n_cmp++; if (port_out !== 8'hAA) begin n_err++; $display("FAIL toggle_port_out got %h want AA", port_out); end
        rd(3'd2);
        n_cmp++; if (rdata !== 8'hAA) begin n_err++; $display("FAIL toggle_read got %h want AA", rdata); end
        addr = 3'd1;
        tick();
        n_cmp++; if (rdata !== 8'hAA) begin n_err++; $display("FAIL rdata_hold got %h want AA", rdata); end
        wr(3'd1, 8'h3C);
        n_cmp++; if (ddr_out !== 8'h3C) begin n_err++; $display("FAIL ddr_load got %h want 3C", ddr_out); end
        rd(3'd0);
        n_cmp++; if (rdata !== 8'hFF) begin n_err++; $display("FAIL pin_read got %h want FF", rdata); end
    endtask

    task automatic test_rise_irq();
        pin_in = 8'h00;
        wr(3'd3, 8'h00);
        wr(3'd4, 8'h00);
        repeat (4) tick();
        wr(3'd5, 8'hFF);
        wr(3'd3, 8'h01);
        tick();
        pin_in = 8'h01;
        addr = 3'd5; re = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 3) begin
                n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rise_irq_early got %b want 0", irq); end
                n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL rise_flag_early got %h want 00", rdata); end
            end
            if (k == 4) begin
                n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL rise_irq got %b want 1", irq); end
                n_cmp++; if (rdata !== 8'h01) begin n_err++; $display("FAIL rise_flag got %h want 01", rdata); end
            end
        end
        re = 1'b0;
        wr(3'd5, 8'h01);
        pin_in = 8'h00;
        repeat (5) tick();
        rd(3'd5);
        n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL fall_ignored_flag got %h want 00", rdata); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL fall_ignored_irq got %b want 0", irq); end
    endtask

    task automatic test_w1c_race();
        wr(3'd3, 8'h03);
        pin_in = 8'h03;
        repeat (4) tick();
        pin_in = 8'h01;
        repeat (4) tick();
        pin_in = 8'h03;
        tick();
        tick();
        wr(3'd5, 8'h03);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL race_irq_a got %b want 1", irq); end
        tick();
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL race_irq_b got %b want 1", irq); end
        rd(3'd5);
        n_cmp++; if (rdata !== 8'h02) begin n_err++; $display("FAIL race_flag got %h want 02", rdata); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL race_irq_c got %b want 1", irq); end
    endtask

    task automatic test_disable();
        wr(3'd5, 8'hFF);
        wr(3'd3, 8'h04);
        pin_in = 8'h07;
        repeat (4) tick();
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL disable_pre_irq got %b want 1", irq); end
        wr(3'd4, 8'h00);
        wr(3'd3, 8'h00);
        tick();
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL disable_irq got %b want 0", irq); end
        rd(3'd5);
        n_cmp++; if (rdata !== 8'h04) begin n_err++; $display("FAIL disable_flag got %h want 04", rdata); end
    endtask

    task automatic test_param();
        pin4 = 4'h8;
        wr4(3'd4, 4'h8);
        repeat (6) tick();
        wr4(3'd5, 4'hF);
        tick();
        pin4 = 4'h0;
        addr4 = 3'd5; re4 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 4) begin
                n_cmp++; if (rdata4 !== 4'h0) begin n_err++; $display("FAIL p4_flag_early got %h want 0", rdata4); end
            end
            if (k == 5) begin
                n_cmp++; if (rdata4 !== 4'h8) begin n_err++; $display("FAIL p4_flag got %h want 8", rdata4); end
                n_cmp++; if (irq4 !== 1'b1) begin n_err++; $display("FAIL p4_irq got %b want 1", irq4); end
            end
        end
        re4 = 1'b0;
        wr4(3'd6, 4'hF);
        addr4 = 3'd6; re4 = 1'b1;
        tick();
        re4 = 1'b0;
        n_cmp++; if (rdata4 !== 4'h0) begin n_err++; $display("FAIL p4_reserved got %h want 0", rdata4); end
    endtask

    task automatic test_reset_mid_access();
        addr = 3'd1; wdata = 8'hFF; we = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (ddr_out !== 8'h00) begin n_err++; $display("FAIL async_clear_ddr got %h want 00", ddr_out); end
        @(posedge clk);
        #1;
        we = 1'b0;
        reset = 1'b0;
        model_reset();
        tick();
        n_cmp++; if (ddr_out !== 8'h00) begin n_err++; $display("FAIL aborted_write_ddr got %h want 00", ddr_out); end
        n_cmp++; if (port_out !== 8'h00) begin n_err++; $display("FAIL mid_reset_port got %h want 00", port_out); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            addr  = 3'($urandom_range(0, 7));
            wdata = 8'($urandom);
            we    = ($urandom_range(0, 2) == 0);
            re    = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 3) == 0) pin_in = 8'($urandom);
            tick();
            n_cmp++; if (rdata !== m_rdata) begin n_err++; $display("FAIL rnd_rdata cyc %0d got %h want %h", i, rdata, m_rdata); end
            n_cmp++; if (port_out !== m_port) begin n_err++; $display("FAIL rnd_port cyc %0d got %h want %h", i, port_out, m_port); end
            n_cmp++; if (ddr_out !== m_ddr) begin n_err++; $display("FAIL rnd_ddr cyc %0d got %h want %h", i, ddr_out, m_ddr); end
            n_cmp++; if (irq !== m_irq) begin n_err++; $display("FAIL rnd_irq cyc %0d got %b want %b", i, irq, m_irq); end
        end
        we = 1'b0;
        re = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_toggle();
        test_rise_irq();
        test_w1c_race();
        test_disable();
        test_param();
        test_reset_mid_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
